// File: rtl/alu_decode_exec.sv
// Decoded ALU with a valid/ready handshake; single-cycle ops finish in one cycle.
// Define ALU_DECODE_EXEC_MULT_EN to add the shift-add MULTU path (otherwise func 25 is ADD, hi is 0).
module alu_decode_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU, OP_MULTU} op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  op_t              op;
  logic [WIDTH-1:0] alu_res;
  logic             accept;

  always_comb begin
    op = OP_ADD;
    case (alu_op)
      2'd1: op = OP_SUB;
      2'd2: begin
        case (func)
          6'd34:   op = OP_SUB;
          6'd36:   op = OP_AND;
          6'd37:   op = OP_OR;
          6'd39:   op = OP_NOR;
          6'd42:   op = OP_SLT;
          6'd43:   op = OP_SLTU;
`ifdef ALU_DECODE_EXEC_MULT_EN
          6'd25:   op = OP_MULTU;
`endif
          default: op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  always_comb begin
    alu_res = a + b;
    case (op)
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = a + b;
    endcase
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

`ifdef ALU_DECODE_EXEC_MULT_EN
  logic [WIDTH-1:0]   hi_q, hi_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     psum;

  // Multiplier sits in the low half of prod and shifts out as the partial sum shifts in.
  assign psum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{prod_q[0]}} & mcand_q)};
  assign hi   = hi_q;
`else
  assign hi   = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_DECODE_EXEC_MULT_EN
    hi_d     = hi_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_DECODE_EXEC_MULT_EN
          if (op == OP_MULTU) begin
            state_d = MUL;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
          end else
`endif
          begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_DECODE_EXEC_MULT_EN
      MUL: begin
        // WIDTH add/shift steps, then one cycle to publish the product.
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DONE;
          result_d = prod_q[WIDTH-1:0];
          hi_d     = prod_q[2*WIDTH-1:WIDTH];
          zero_d   = (prod_q[WIDTH-1:0] == '0);
        end else begin
          prod_d = {psum, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_DECODE_EXEC_MULT_EN
      hi_q     <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_DECODE_EXEC_MULT_EN
      hi_q     <= hi_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
